led_stretch: RTL and testbench

Multi-channel output pulse stretcher. It turns single-cycle event strobes from game logic (hit, miss, mole-up) into LED flashes a human can see. Each flash has a guaranteed minimum on-time and a guaranteed off-gap, so that back-to-back events appear as distinct flashes. It sits between the game FSM and the board LED pins, and is the output-side counterpart of the button input conditioning.

---
 rtl/stretch_pkg.sv | 17 +
 rtl/stretch_channel.sv | 137 +++++++++++++
 rtl/led_stretch.sv | 42 ++++
 tb/tb_led_stretch.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stretch_pkg.sv
// stretch_pkg: shared types and constants for the LED pulse stretcher.
// State encoding, counter width and pend-width helper.
package stretch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam int CNT_W = 16;

    function automatic int pend_width(input int pmax);
        return (pmax < 1) ? 1 : $clog2(pmax + 1);
    endfunction

endpackage

// File: rtl/stretch_channel.sv
// stretch_channel: one stretcher FSM (IDLE/HOLD/GAP) with cnt and pend.
// Ports: clk, rst (async, high), trig, led, busy, drop (all outputs registered).
// Queueing of triggers is compiled in when STRETCH_QUEUE_EN is defined.
module stretch_channel
    import stretch_pkg::*;
#(
    parameter logic [CNT_W-1:0] HOLD_CNT = 16'd50000,
    parameter logic [CNT_W-1:0] GAP_CNT  = 16'd25000
`ifdef STRETCH_QUEUE_EN
    ,
    parameter int PEND_MAX = 3
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic led,
    output logic busy,
    output logic drop
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hold_end;
    logic             gap_end;
    logic             late_trig;
    logic             drop_d;
    logic             busy_d;

`ifdef STRETCH_QUEUE_EN
    localparam int PW = pend_width(PEND_MAX);
    localparam logic [PW-1:0] PEND_LIM = PW'(PEND_MAX);

    logic [PW-1:0] pend_q;
    logic [PW-1:0] pend_d;
`endif

    assign hold_end = (cnt_q == HOLD_CNT - 1'b1);
    assign gap_end  = (cnt_q == GAP_CNT - 1'b1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        late_trig = 1'b0;
        drop_d    = 1'b0;
`ifdef STRETCH_QUEUE_EN
        pend_d    = pend_q;
`endif

        unique case (1'b1)
            (state_q == ST_HOLD): begin
                late_trig = trig;
                if (hold_end) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            (state_q == ST_GAP): begin
                if (gap_end) begin
                    cnt_d = '0;
`ifdef STRETCH_QUEUE_EN
                    // A trigger on this cycle refills the slot being
                    // consumed, so pend only drops without one.
                    if (pend_q != '0) begin
                        state_d = ST_HOLD;
                        if (!trig) begin
                            pend_d = pend_q - 1'b1;
                        end
                    end else
`endif
                    if (trig) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    late_trig = trig;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = trig ? ST_HOLD : ST_IDLE;
            end
        endcase

        if (late_trig) begin
`ifdef STRETCH_QUEUE_EN
            if (pend_q < PEND_LIM) begin
                pend_d = pend_q + 1'b1;
            end else begin
                drop_d = 1'b1;
            end
`else
            drop_d = 1'b1;
`endif
        end
    end

`ifdef STRETCH_QUEUE_EN
    assign busy_d = (state_d != ST_IDLE) || (pend_d != '0);
`else
    assign busy_d = (state_d != ST_IDLE);
`endif

    // Outputs are registered from next-state so they line up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            led     <= 1'b0;
            busy    <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led     <= (state_d == ST_HOLD);
            busy    <= busy_d;
            drop    <= drop_d;
        end
    end

`ifdef STRETCH_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

endmodule

// File: rtl/led_stretch.sv
// led_stretch: multi-channel LED pulse stretcher (min on-time + off-gap).
// Ports: clk, rst (async, high), trig_in[NUM_CH], led_out, busy, drop_pulse.
// Macro STRETCH_QUEUE_EN enables per-channel trigger queueing (PEND_MAX).
module led_stretch
    import stretch_pkg::*;
#(
    parameter int               NUM_CH   = 4,
    parameter logic [CNT_W-1:0] HOLD_CNT = 16'd50000,
    parameter logic [CNT_W-1:0] GAP_CNT  = 16'd25000,
    parameter int               PEND_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trig_in,
    output logic [NUM_CH-1:0] led_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] drop_pulse
);

    if (HOLD_CNT == '0 || GAP_CNT == '0 || PEND_MAX < 1) begin : g_bad_cfg
        $error("led_stretch: HOLD_CNT, GAP_CNT and PEND_MAX must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stretch_channel #(
            .HOLD_CNT (HOLD_CNT),
            .GAP_CNT  (GAP_CNT)
`ifdef STRETCH_QUEUE_EN
            ,
            .PEND_MAX (PEND_MAX)
`endif
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .trig (trig_in[i]),
            .led  (led_out[i]),
            .busy (busy[i]),
            .drop (drop_pulse[i])
        );
    end

endmodule

// File: tb/tb_led_stretch.sv
// tb_led_stretch: directed + randomized checks of led_stretch against
// a timeline model (flash start cycle + pending count per channel).
module tb_led_stretch;

    localparam int N  = 4;
    localparam int H  = 4;
    localparam int G  = 2;
    localparam int PM = 2;
`ifdef STRETCH_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] trig_in;
    logic [N-1:0] led_out;
    logic [N-1:0] busy;
    logic [N-1:0] drop_pulse;

    always #5 clk = ~clk;

    led_stretch #(
        .NUM_CH   (N),
        .HOLD_CNT (16'd4),
        .GAP_CNT  (16'd2),
        .PEND_MAX (PM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig_in    (trig_in),
        .led_out    (led_out),
        .busy       (busy),
        .drop_pulse (drop_pulse)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int r [N];
    int pend [N];
    logic [N-1:0] exp_led;
    logic [N-1:0] exp_busy;
    logic [N-1:0] exp_drop;

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            r[c]    = -1000;
            pend[c] = 0;
        end
        exp_led  = '0;
        exp_busy = '0;
        exp_drop = '0;
    endtask

    // r = first lit cycle of the current/last flash; flash occupies
    // r .. r+H-1 lit, r+H .. r+H+G-1 dark. Next flash may rise at r+H+G.
    task automatic model_step(input logic [N-1:0] t);
        int nx;
        nx = cyc + 1;
        for (int c = 0; c < N; c++) begin
            exp_drop[c] = 1'b0;
            if (pend[c] > 0 && cyc == r[c] + H + G - 1) begin
                r[c]    = cyc + 1;
                pend[c] = pend[c] - 1;
            end
            if (t[c]) begin
                if (cyc >= r[c] + H + G - 1) r[c] = cyc + 1;
                else if (QEN && pend[c] < PM) pend[c] = pend[c] + 1;
                else exp_drop[c] = 1'b1;
            end
            exp_led[c]  = (nx >= r[c]) && (nx < r[c] + H);
            exp_busy[c] = ((nx >= r[c]) && (nx < r[c] + H + G)) || pend[c] > 0;
        end
    endtask

    task automatic tick(input logic [N-1:0] t);
        trig_in = t;
        model_step(t);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        trig_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        trig_in = '0;
        #1;
        n_cmp++;
        if (led_out !== '0 || busy !== '0 || drop_pulse !== '0) begin
            n_bad++;
            $display("FAIL reset_async led=%b busy=%b drop=%b want 0", led_out, busy, drop_pulse);
        end
        do_reset();
        n_cmp++;
        if (led_out !== '0) begin
            n_bad++;
            $display("FAIL reset_led got=%b want=0", led_out);
        end
        n_cmp++;
        if (busy !== '0) begin
            n_bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        n_cmp++;
        if (drop_pulse !== '0) begin
            n_bad++;
            $display("FAIL reset_drop got=%b want=0", drop_pulse);
        end
    endtask

    task automatic test_single();
        logic [N-1:0] t;
        logic el, eb;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            t = '0;
            if (i == 10) t[0] = 1'b1;
            tick(t);
            el = (cyc >= 11 && cyc <= 14);
            eb = (cyc >= 11 && cyc <= 16);
            n_cmp++;
            if (led_out[0] !== el || busy[0] !== eb) begin
                n_bad++;
                $display("FAIL single cyc=%0d led=%b busy=%b want %b %b", cyc, led_out[0], busy[0], el, eb);
            end
            n_cmp++;
            if (led_out[N-1:1] !== '0 || busy[N-1:1] !== '0 || drop_pulse !== '0) begin
                n_bad++;
                $display("FAIL single_quiet cyc=%0d led=%b busy=%b drop=%b want others 0", cyc, led_out, busy, drop_pulse);
            end
        end
    endtask

    task automatic test_two();
        logic [N-1:0] t;
        logic el, ed;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            t = '0;
            if (i == 10 || i == 12) t[0] = 1'b1;
            tick(t);
            el = (cyc >= 11 && cyc <= 14) || (QEN && cyc >= 17 && cyc <= 20);
            ed = !QEN && cyc == 13;
            n_cmp++;
            if (led_out[0] !== el || drop_pulse[0] !== ed) begin
                n_bad++;
                $display("FAIL two cyc=%0d led=%b drop=%b want %b %b", cyc, led_out[0], drop_pulse[0], el, ed);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL two_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
        end
    endtask

    task automatic test_burst();
        logic [N-1:0] t;
        logic el, ed, eb;
        do_reset();
        for (int i = 0; i < 34; i++) begin
            t = '0;
            if (i >= 10 && i <= 13) t[0] = 1'b1;
            tick(t);
            if (QEN) begin
                el = (cyc >= 11 && cyc <= 14) || (cyc >= 17 && cyc <= 20) || (cyc >= 23 && cyc <= 26);
                ed = (cyc == 14);
                eb = (cyc >= 11 && cyc <= 28);
            end else begin
                el = (cyc >= 11 && cyc <= 14);
                ed = (cyc >= 12 && cyc <= 14);
                eb = (cyc >= 11 && cyc <= 16);
            end
            n_cmp++;
            if (led_out[0] !== el || drop_pulse[0] !== ed || busy[0] !== eb) begin
                n_bad++;
                $display("FAIL burst cyc=%0d led=%b drop=%b busy=%b want %b %b %b", cyc, led_out[0], drop_pulse[0], busy[0], el, ed, eb);
            end
        end
    endtask

    task automatic test_gap_retrig();
        logic [N-1:0] t;
        logic el, eb;
        do_reset();
        for (int i = 0; i < 28; i++) begin
            t = '0;
            if (i == 10 || i == 16) t[0] = 1'b1;
            tick(t);
            el = (cyc >= 11 && cyc <= 14) || (cyc >= 17 && cyc <= 20);
            eb = (cyc >= 11 && cyc <= 22);
            n_cmp++;
            if (led_out[0] !== el || busy[0] !== eb || drop_pulse[0] !== 1'b0) begin
                n_bad++;
                $display("FAIL gap_retrig cyc=%0d led=%b busy=%b drop=%b want %b %b 0", cyc, led_out[0], busy[0], drop_pulse[0], el, eb);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] t;
        logic el;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            t = '0;
            if (i == 10 || i == 11) t[0] = 1'b1;
            tick(t);
        end
        trig_in = '0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (led_out !== '0 || busy !== '0 || drop_pulse !== '0) begin
            n_bad++;
            $display("FAIL reset_mid led=%b busy=%b drop=%b want 0", led_out, busy, drop_pulse);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        cyc = 13;
        for (int i = 13; i < 30; i++) begin
            t = '0;
            if (i == 20) t[0] = 1'b1;
            tick(t);
            el = (cyc >= 21 && cyc <= 24);
            n_cmp++;
            if (led_out[0] !== el || busy !== exp_busy) begin
                n_bad++;
                $display("FAIL reset_mid_after cyc=%0d led=%b busy=%b want %b %b", cyc, led_out[0], busy, el, exp_busy);
            end
        end
    endtask

    task automatic test_all_channels();
        logic [N-1:0] t;
        logic [N-1:0] el;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            t = (i == 10) ? '1 : '0;
            tick(t);
            el = (cyc >= 11 && cyc <= 14) ? '1 : '0;
            n_cmp++;
            if (led_out !== el) begin
                n_bad++;
                $display("FAIL all_ch cyc=%0d got=%b want=%b", cyc, led_out, el);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] t;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                trig_in = '0;
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                model_clear();
                cyc++;
            end
            for (int b = 0; b < N; b++) t[b] = ($urandom_range(0, 2) == 0);
            tick(t);
            n_cmp++;
            if (led_out !== exp_led) begin
                n_bad++;
                $display("FAIL rand_led cyc=%0d got=%b want=%b", cyc, led_out, exp_led);
            end
            n_cmp++;
            if (busy !== exp_busy) begin
                n_bad++;
                $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc, busy, exp_busy);
            end
            n_cmp++;
            if (drop_pulse !== exp_drop) begin
                n_bad++;
                $display("FAIL rand_drop cyc=%0d got=%b want=%b", cyc, drop_pulse, exp_drop);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        trig_in = '0;
        cyc = 0;
        model_clear();
        test_reset();
        test_single();
        test_two();
        test_burst();
        test_gap_retrig();
        test_reset_mid();
        test_all_channels();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
